hex_page_ctrl: RTL

Board-level controller that sequences the DE2 test front panel: it debounces two pushbuttons and captures 16-bit switch snapshots into a small ring buffer. It also pages through the stored snapshots for display. Its `disp_value` output drives the four `hex7seg` digit decoders (nibbles 3..0 → HEX3..HEX0), and its byte outputs drive the two LCD byte lanes. It sits between the raw `KEY`/`SW` pins and the display decoders in the board top.

---
 rtl/hex_page_pkg.sv | 19 +
 rtl/hex_page_ctrl_key_debounce.sv | 46 ++++
 rtl/hex_page_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/hex_page_pkg.sv
// Shared constants, default-depth width typedefs and the page-advance helper
// for the DE2 front-panel snapshot pager.
package hex_page_pkg;

  localparam int unsigned DEFAULT_DEB_CYCLES    = 1_000_000;
  localparam int unsigned DEFAULT_SCROLL_CYCLES = 50_000_000;
  localparam int unsigned DEFAULT_DEPTH         = 4;
  localparam int unsigned PAGE_W                = $clog2(DEFAULT_DEPTH);

  typedef logic [PAGE_W-1:0] page_t;
  typedef logic [PAGE_W:0]   count_t;

  // Next slot in insertion order, wrapping at the number of valid slots.
  function automatic int unsigned next_slot(input int unsigned page,
                                            input int unsigned valid);
    return (page + 1 >= valid) ? 0 : page + 1;
  endfunction

endpackage

// File: rtl/hex_page_ctrl_key_debounce.sv
// Two-flop synchronizer plus counting debouncer for one active-low pushbutton;
// emits a one-cycle strobe when a press (1->0) is accepted.
module key_debounce
  import hex_page_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        // Old level high means this acceptance is a press, not a release.
        press <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hex_page_ctrl.sv
// DE2 front-panel controller: debounced store/step keys capture SW snapshots
// into a ring buffer and page through them. Optional macro HEX_PAGE_AUTOSCROLL_EN.
module hex_page_ctrl
  import hex_page_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEFAULT_DEB_CYCLES,
  parameter int unsigned DEPTH         = DEFAULT_DEPTH,
  parameter int unsigned SCROLL_CYCLES = DEFAULT_SCROLL_CYCLES
) (
  input  logic                     CLOCK_50,
  input  logic                     KEY0,
  input  logic                     key_step_n,
  input  logic                     key_store_n,
  input  logic [15:0]              sw_data,
  output logic [15:0]              disp_value,
  output logic [7:0]               lcd_hi,
  output logic [7:0]               lcd_lo,
  output logic [$clog2(DEPTH)-1:0] page_idx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     store_pulse
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic          step_press;
  logic          store_press;
  logic          auto_ev;
  logic          step_ev;
  logic [PW-1:0] wr_ptr;
  logic [15:0]   mem [DEPTH];

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .key_n (key_step_n),
    .press (step_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_store_deb (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .key_n (key_store_n),
    .press (store_press)
  );

`ifdef HEX_PAGE_AUTOSCROLL_EN
  localparam int unsigned SCW = $clog2(SCROLL_CYCLES + 1);
  localparam logic [SCW-1:0] SCROLL_LAST = SCW'(SCROLL_CYCLES - 1);

  logic [SCW-1:0] scroll_cnt;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      scroll_cnt <= '0;
    end else if (store_press || step_press || count < CW'(2)) begin
      scroll_cnt <= '0;
    end else if (scroll_cnt == SCROLL_LAST) begin
      scroll_cnt <= '0;
    end else begin
      scroll_cnt <= scroll_cnt + SCW'(1);
    end
  end

  assign auto_ev = (scroll_cnt == SCROLL_LAST) && (count >= CW'(2))
                   && !store_press && !step_press;
`else
  assign auto_ev = 1'b0 & (SCROLL_CYCLES == 0);
`endif

  // A store in the same cycle wins; the step is dropped entirely.
  assign step_ev = (step_press | auto_ev) & ~store_press;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      wr_ptr      <= '0;
      page_idx    <= '0;
      count       <= '0;
      store_pulse <= 1'b0;
    end else begin
      store_pulse <= store_press;
      if (store_press) begin
        page_idx <= wr_ptr;
        wr_ptr   <= wr_ptr + PW'(1);
        if (!full) count <= count + CW'(1);
      end else if (step_ev && count != '0) begin
        page_idx <= PW'(next_slot(32'(page_idx), 32'(count)));
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (store_press) mem[wr_ptr] <= sw_data;
  end

  assign full       = (count == CW'(DEPTH));
  assign disp_value = (count == '0) ? 16'h0000 : mem[page_idx];
  assign lcd_hi     = disp_value[15:8];
  assign lcd_lo     = disp_value[7:0];

endmodule
